// File: rtl/dma_cfg_pkg.sv
// Shared types and constants for the DMA configuration-port AXI4-Lite master.
// Holds the FSM state encoding, AXI response codes and DMA register offsets.
package dma_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP,
    HUNG
  } dma_cfg_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [7:0] REG_CTRL   = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam logic [7:0] REG_SRC    = 8'h0C;
  localparam logic [7:0] REG_DST    = 8'h10;
  localparam logic [7:0] REG_LEN    = 8'h14;

endpackage

// File: rtl/dma_cfg_wdog.sv
// Transaction watchdog: 16-bit cycle counter with clear/enable; expired holds once LIMIT is reached.
// Only built into the master when DMA_CFG_TIMEOUT_EN is defined.
module dma_cfg_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] count_q;

  assign expired_o = (count_q == 16'(LIMIT));

  // Saturate at the limit so a stuck transaction never wraps back to "not expired".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && !expired_o) begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: rtl/dma_cfg_axil_master.sv
// Single-outstanding AXI4-Lite master for the DMA register block; command in, response out.
// Optional watchdog (macro DMA_CFG_TIMEOUT_EN) parks the FSM in HUNG with a DECERR/timeout response.
module dma_cfg_axil_master
  import dma_cfg_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] cfg_m_axi_awaddr,
  output logic              cfg_m_axi_awvalid,
  input  logic              cfg_m_axi_awready,
  output logic [31:0]       cfg_m_axi_wdata,
  output logic [3:0]        cfg_m_axi_wstrb,
  output logic              cfg_m_axi_wvalid,
  input  logic              cfg_m_axi_wready,
  input  logic [1:0]        cfg_m_axi_bresp,
  input  logic              cfg_m_axi_bvalid,
  output logic              cfg_m_axi_bready,
  output logic [ADDR_W-1:0] cfg_m_axi_araddr,
  output logic              cfg_m_axi_arvalid,
  input  logic              cfg_m_axi_arready,
  input  logic [31:0]       cfg_m_axi_rdata,
  input  logic [1:0]        cfg_m_axi_rresp,
  input  logic              cfg_m_axi_rvalid,
  output logic              cfg_m_axi_rready
);

  dma_cfg_state_e    state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              write_q;
  logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic              rsp_valid_q, rsp_write_q, rsp_timeout_q;
  logic [31:0]       rsp_rdata_q;
  logic [1:0]        rsp_resp_q;
  logic              aw_fin, w_fin;
  logic              wdog_expired;

`ifdef DMA_CFG_TIMEOUT_EN
  logic wdog_clr, wdog_en;

  assign wdog_clr = (state_q == IDLE) && cmd_valid;
  assign wdog_en  = (state_q == WR) || (state_q == WR_RESP) ||
                    (state_q == RD_ADDR) || (state_q == RD_DATA);

  dma_cfg_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wdog_clr),
    .en_i      (wdog_en),
    .expired_o (wdog_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wdog_expired       = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // A channel counts as finished if it already handshook earlier or does so this cycle.
  assign aw_fin = !awvalid_q || cfg_m_axi_awready;
  assign w_fin  = !wvalid_q  || cfg_m_axi_wready;

  assign cfg_m_axi_awaddr  = addr_q;
  assign cfg_m_axi_araddr  = addr_q;
  assign cfg_m_axi_wdata   = wdata_q;
  assign cfg_m_axi_wstrb   = wstrb_q;
  assign cfg_m_axi_awvalid = awvalid_q;
  assign cfg_m_axi_wvalid  = wvalid_q;
  assign cfg_m_axi_bready  = bready_q;
  assign cfg_m_axi_arvalid = arvalid_q;
  assign cfg_m_axi_rready  = rready_q;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      write_q       <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else if (wdog_expired && (state_q != HUNG)) begin
      // Outstanding valids are deliberately left asserted so the AXI side stays legal.
      state_q       <= HUNG;
      rsp_valid_q   <= 1'b1;
      rsp_write_q   <= write_q;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_DECERR;
      rsp_timeout_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            write_q <= cmd_write;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        WR: begin
          if (cfg_m_axi_awready) awvalid_q <= 1'b0;
          if (cfg_m_axi_wready)  wvalid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (cfg_m_axi_bvalid) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= cfg_m_axi_bresp;
            state_q     <= RSP;
          end
        end
        RD_ADDR: begin
          if (cfg_m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (cfg_m_axi_rvalid) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= cfg_m_axi_rdata;
            rsp_resp_q  <= cfg_m_axi_rresp;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        HUNG: begin
          state_q <= HUNG;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cfg_axil_master.sv
// Directed bench for dma_cfg_axil_master against a small AXI4-Lite register-block model.
// The timeout scenario is only exercised when DMA_CFG_TIMEOUT_EN is defined.
module tb_dma_cfg_axil_master;
  import dma_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_vec = 0;
  int n_err = 0;

  // Slave model knobs and state.
  int          aw_dly = 1, w_dly = 1, ar_dly = 1;
  logic        ar_block = 1'b0;
  int          aw_wait, w_wait, ar_wait, b_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  logic [31:0] mem [0:7];

  always #5 clk = ~clk;

  dma_cfg_axil_master #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .cfg_m_axi_awaddr(awaddr), .cfg_m_axi_awvalid(awvalid), .cfg_m_axi_awready(awready),
    .cfg_m_axi_wdata(wdata), .cfg_m_axi_wstrb(wstrb), .cfg_m_axi_wvalid(wvalid),
    .cfg_m_axi_wready(wready), .cfg_m_axi_bresp(bresp), .cfg_m_axi_bvalid(bvalid),
    .cfg_m_axi_bready(bready), .cfg_m_axi_araddr(araddr), .cfg_m_axi_arvalid(arvalid),
    .cfg_m_axi_arready(arready), .cfg_m_axi_rdata(rdata), .cfg_m_axi_rresp(rresp),
    .cfg_m_axi_rvalid(rvalid), .cfg_m_axi_rready(rready)
  );

  function automatic logic legal(input logic [31:0] a);
    return (a[31:5] == 27'd0) && (a[1:0] == 2'b00) && (a[4:2] >= 3'd1) && (a[4:2] <= 3'd5);
  endfunction

  assign awready = awvalid && !aw_got && (aw_wait == aw_dly);
  assign wready  = wvalid && !w_got && (w_wait == w_dly);
  assign arready = arvalid && !ar_block && !rvalid && (ar_wait == ar_dly);

  // Register-block model: ready after a programmable wait, response one cycle after the last handshake.
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      logic        aw_now, w_now;
      logic [31:0] a, d;
      logic [3:0]  s;
      aw_now = aw_got || (awvalid && awready);
      w_now  = w_got || (wvalid && wready);
      a = (awvalid && awready) ? awaddr : aw_addr_s;
      d = (wvalid && wready) ? wdata : w_data_s;
      s = (wvalid && wready) ? wstrb : w_strb_s;
      if (awvalid && !awready && !aw_got) aw_wait <= aw_wait + 1;
      if (wvalid && !wready && !w_got) w_wait <= w_wait + 1;
      if (awvalid && awready) aw_addr_s <= awaddr;
      if (wvalid && wready) begin w_data_s <= wdata; w_strb_s <= wstrb; end
      if (aw_now && w_now && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= legal(a) ? RESP_OKAY : RESP_SLVERR;
        if (legal(a))
          for (int b = 0; b < 4; b++)
            if (s[b]) mem[a[4:2]][8*b +: 8] <= d[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; w_wait <= 0;
      end else begin
        aw_got <= aw_now;
        w_got  <= w_now;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; b_cnt <= b_cnt + 1; end
      if (arvalid && !arready && !rvalid) ar_wait <= ar_wait + 1;
      if (arvalid && arready) begin
        rvalid  <= 1'b1;
        rdata   <= legal(araddr) ? mem[araddr[4:2]] : 32'd0;
        rresp   <= legal(araddr) ? RESP_OKAY : RESP_SLVERR;
        ar_wait <= 0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  initial b_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one command, measures accept-to-rsp_valid latency, holds rsp_ready low for 'hold' cycles.
  task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, output int lat,
                        output int aw_only, output int w_only, output logic r_wr,
                        output logic [31:0] r_data, output logic [1:0] r_resp, output logic r_to);
    int guard = 0;
    lat = 0; aw_only = 0; w_only = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("cmd_accept", {63'd0, cmd_ready}, 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      if (awvalid && !wvalid) aw_only++;
      if (!awvalid && wvalid) w_only++;
      @(negedge clk);
      lat++;
    end
    chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
    r_wr = rsp_write; r_data = rsp_rdata; r_resp = rsp_resp; r_to = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold", {27'd0, rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata},
          {27'd0, 1'b1, 1'b0, r_wr, r_resp, r_data});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, awo, wo, b0, guard;
    logic r_wr, r_to;
    logic [31:0] r_data;
    logic [1:0] r_resp;
    logic seen;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {56'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, rsp_timeout}, 64'd0);
    chk("reset_rsp", {30'd0, rsp_write, rsp_resp, rsp_rdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", {62'd0, cmd_ready, busy}, 64'd2);

    // Plain write, then read back.
    do_cmd(1'b1, {24'd0, REG_SRC}, 32'h1000_0000, 4'hF, 0, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("wr_ok_resp", {29'd0, r_wr, r_resp, r_to}, {29'd0, 1'b1, 2'b00, 1'b0});
    chk("wr_ok_rdata", {32'd0, r_data}, 64'd0);
    chk("wr_ok_lat", 64'(lat), 64'd4);
    chk("wr_ok_bcnt", 64'(b_cnt), 64'd1);
    chk("cmd_ready_after", {63'd0, cmd_ready}, 64'd1);

    do_cmd(1'b0, 32'h0000_000C, 32'h0, 4'h0, 0, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("rd_back_data", {32'd0, r_data}, 64'h1000_0000);
    chk("rd_back_resp", {61'd0, r_wr, r_resp}, {61'd0, 1'b0, 2'b00});
    chk("rd_back_lat", 64'(lat), 64'd4);

    // Unmapped address answered with SLVERR on both paths.
    do_cmd(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 0, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("wr_bad_resp", {62'd0, r_resp}, 64'd2);
    do_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("rd_bad", {30'd0, r_resp, r_data}, {30'd0, 2'b10, 32'd0});

    // Partial strobes: only bytes 0 and 2 land.
    do_cmd(1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'b0101, 0, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    do_cmd(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("strobe_data", {32'd0, r_data}, 64'h00BB_00DD);

    // AW accepted three cycles ahead of W.
    aw_dly = 1; w_dly = 4; b0 = b_cnt;
    do_cmd(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 0, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("skew_aw_first_w_only", 64'(wo), 64'd3);
    chk("skew_aw_first_aw_only", 64'(awo), 64'd0);
    chk("skew_aw_first_lat", 64'(lat), 64'd7);
    chk("skew_aw_first_bcnt", 64'(b_cnt - b0), 64'd1);

    // W accepted ahead of AW.
    aw_dly = 3; w_dly = 1; b0 = b_cnt;
    do_cmd(1'b1, 32'h0000_0014, 32'h0000_0100, 4'hF, 0, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("skew_w_first_aw_only", 64'(awo), 64'd2);
    chk("skew_w_first_lat", 64'(lat), 64'd6);
    chk("skew_w_first_bcnt", 64'(b_cnt - b0), 64'd1);
    aw_dly = 1; w_dly = 1;
    do_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("skew_readback", {32'd0, r_data}, 64'h1234_5678);

    // Response back-pressure for five cycles.
    do_cmd(1'b0, 32'h0000_0014, 32'h0, 4'h0, 5, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("bp_data", {32'd0, r_data}, 64'h0000_0100);
    chk("bp_retired", {62'd0, rsp_valid, cmd_ready}, 64'd1);

    // Reset while stuck in WR abandons the write.
    aw_dly = 20; w_dly = 20; b0 = b_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_000C;
    cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_wr_state", {61'd0, busy, awvalid, wvalid}, 64'd7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr", {60'd0, awvalid, wvalid, busy, rsp_valid}, 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen = seen | rsp_valid | busy; end
    chk("rst_no_rsp", {63'd0, seen}, 64'd0);
    chk("rst_no_b", 64'(b_cnt - b0), 64'd0);
    aw_dly = 1; w_dly = 1;
    do_cmd(1'b0, 32'h0000_000C, 32'h0, 4'h0, 0, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("rst_rd_after", {30'd0, r_resp, r_data}, 64'd0);

`ifdef DMA_CFG_TIMEOUT_EN
    // Slave never accepts AR; watchdog parks the master in HUNG.
    ar_block = 1'b1;
    do_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0, 3, lat, awo, wo, r_wr, r_data, r_resp, r_to);
    chk("to_flags", {61'd0, r_to, r_resp}, {61'd0, 1'b1, 2'b11});
    repeat (4) @(negedge clk);
    chk("to_hung", {61'd0, arvalid, cmd_ready, rsp_valid}, {61'd0, 1'b1, 1'b0, 1'b1});
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; ar_block = 1'b0;
    @(negedge clk);
    chk("to_reset_exit", {61'd0, arvalid, cmd_ready, rsp_timeout}, {61'd0, 1'b0, 1'b1, 1'b0});
`endif

    guard = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
